// File: rtl/flowid_reclaimer_pkg.sv
// flowid_reclaimer_pkg: shared flow ID width, default TIME_WAIT hold and output register states
package flowid_reclaimer_pkg;
    localparam int FLOWID_W = 4;
    localparam int TIME_WAIT_CYCLES_DEFAULT = 1024;
    typedef enum logic {RET_EMPTY, RET_VALID} ret_state_e;
endpackage

// File: rtl/flowid_reclaimer_if.sv
// flowid_reclaimer_if: teardown push side and allocator return side of the reclaimer
interface flowid_reclaimer_if;
    import flowid_reclaimer_pkg::*;
    logic                close_val;
    logic [FLOWID_W-1:0] close_flowid;
    logic                close_rdy;
    logic                flowid_ret_val;
    logic [FLOWID_W-1:0] flowid_ret_id;
    logic                flowid_ret_rdy;
    logic [FLOWID_W:0]   pending_cnt;
    modport master (
        output close_val, close_flowid, flowid_ret_rdy,
        input  close_rdy, flowid_ret_val, flowid_ret_id, pending_cnt
    );
    modport slave (
        input  close_val, close_flowid, flowid_ret_rdy,
        output close_rdy, flowid_ret_val, flowid_ret_id, pending_cnt
    );
endinterface

// File: rtl/flowid_reclaimer_fifo.sv
// fifo_1r1w: show-ahead single-clock FIFO; rst_adapter: async-assert/sync-deassert reset
module fifo_1r1w #(
    parameter int width_p    = 8,
    parameter int log2_els_p = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [width_p-1:0] wr_data,
    output logic               full,
    input  logic               rd_en,
    output logic [width_p-1:0] rd_data,
    output logic               empty
);
    localparam int PW = log2_els_p + 1;
    logic [width_p-1:0] mem [0:(1<<log2_els_p)-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_en & ~full);
            rd_ptr <= rd_ptr + PW'(rd_en & ~empty);
        end
    always_ff @(posedge clk)
        if (wr_en & ~full) mem[wr_ptr[log2_els_p-1:0]] <= wr_data;
    // Extra pointer bit separates full from empty when the indices match
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {log2_els_p{1'b0}}};
    assign empty   = wr_ptr == rd_ptr;
    assign rd_data = mem[rd_ptr[log2_els_p-1:0]];
endmodule

module rst_adapter (
    input  logic clk,
    input  logic rst_async,
    output logic rst
);
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst_async)
        if (rst_async) sync <= 2'b11;
        else           sync <= {sync[0], 1'b0};
    assign rst = sync[1];
endmodule

// File: rtl/flowid_reclaimer.sv
// flowid_reclaimer: holds closed flow IDs for TIME_WAIT_CYCLES, then returns them to the allocator in close order
module flowid_reclaimer import flowid_reclaimer_pkg::*; #(
    parameter int TIME_WAIT_CYCLES = TIME_WAIT_CYCLES_DEFAULT,
    parameter int TS_W             = 32
) (
    input logic             clk,
    input logic             rst_n,
    flowid_reclaimer_if.slave bus
);
    localparam logic [TS_W-1:0] HOLD = TS_W'(TIME_WAIT_CYCLES);
    localparam int CW = FLOWID_W + 1;
    logic [TS_W-1:0]          now;
    logic [TS_W-1:0]          head_ts;
    logic [FLOWID_W-1:0]      head_id;
    logic [FLOWID_W-1:0]      id_q;
    logic [FLOWID_W+TS_W-1:0] head;
    logic [CW-1:0]            cnt_q;
    logic                     fifo_rst, full, empty, aged, push, pop, fire;
    ret_state_e               state, state_nx;

    rst_adapter u_rst (.clk(clk), .rst_async(~rst_n), .rst(fifo_rst));

    fifo_1r1w #(.width_p(FLOWID_W + TS_W), .log2_els_p(FLOWID_W)) u_fifo (
        .clk(clk), .rst(fifo_rst),
        .wr_en(push), .wr_data({bus.close_flowid, now}), .full(full),
        .rd_en(pop), .rd_data(head), .empty(empty)
    );

    assign {head_id, head_ts} = head;
    // Held off while the queue is still leaving reset so no close is dropped
    assign bus.close_rdy = ~full & ~fifo_rst;
    assign push = bus.close_val & bus.close_rdy;
    // Modular difference keeps the age test correct across counter wrap
    assign aged = ~empty & ((now - head_ts) >= HOLD);
    assign pop  = aged & ((state == RET_EMPTY) | bus.flowid_ret_rdy);
    assign fire = bus.flowid_ret_val & bus.flowid_ret_rdy;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RET_EMPTY;
        else        state <= state_nx;

    always_comb
        state_nx = (pop | ((state == RET_VALID) & ~bus.flowid_ret_rdy)) ? RET_VALID : RET_EMPTY;

    always_comb begin
        bus.flowid_ret_val = state == RET_VALID;
        bus.flowid_ret_id  = id_q;
        bus.pending_cnt    = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            now   <= '0;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            now   <= now + TS_W'(1);
            if (pop) id_q <= head_id;
            cnt_q <= cnt_q + CW'(push) - CW'(fire);
        end
endmodule

// File: tb/tb_flowid_reclaimer.sv
// tb_flowid_reclaimer: directed tests against a cycle-level queue model of the reclaimer
module tb_flowid_reclaimer;
    import flowid_reclaimer_pkg::*;
    localparam int TW    = 16;
    localparam int DEPTH = 1 << FLOWID_W;

    typedef struct {
        logic [FLOWID_W-1:0] id;
        int                  due;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    ent_t                q[$];
    logic                mv = 1'b0;
    logic [FLOWID_W-1:0] mid = '0;
    logic                m_pop, m_acc;

    flowid_reclaimer_if bus();
    flowid_reclaimer #(.TIME_WAIT_CYCLES(TW), .TS_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: an ID closed in cycle c is due back in cycle c+TW+1, in close order, one per cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mv = 1'b0;
        end else begin
            m_pop = (!mv || bus.flowid_ret_rdy) && q.size() > 0 && q[0].due <= cyc + 1;
            m_acc = bus.close_val && q.size() < DEPTH;
            if (mv && bus.flowid_ret_rdy) mv = 1'b0;
            if (m_pop) begin
                mv  = 1'b1;
                mid = q[0].id;
                q.pop_front();
            end
            if (m_acc) q.push_back('{bus.close_flowid, cyc + TW + 1});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ret_val", bus.flowid_ret_val, 0);
            chk("rst_ret_id", bus.flowid_ret_id, 0);
            chk("rst_pending", bus.pending_cnt, 0);
        end else begin
            chk("ret_val", bus.flowid_ret_val, mv);
            if (mv) chk("ret_id", bus.flowid_ret_id, mid);
            chk("pending_cnt", bus.pending_cnt, q.size() + int'(mv));
            if (cyc >= rel_cyc + 4) chk("close_rdy", bus.close_rdy, q.size() < DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic close_one(input logic [FLOWID_W-1:0] id, output int t);
        bus.close_val    = 1'b1;
        bus.close_flowid = id;
        t = cyc;
        tick();
        bus.close_val = 1'b0;
    endtask

    task automatic wait_ret(input string name, output int c, output logic [FLOWID_W-1:0] id);
        c  = -1;
        id = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.flowid_ret_val) begin
                c  = cyc;
                id = bus.flowid_ret_id;
                return;
            end
        end
        nchk++;
        nerr++;
        $display("FAIL %s: no flowid_ret_val within 60 cycles, required one", name);
    endtask

    initial begin
        int                  t, t0, c, n;
        logic [FLOWID_W-1:0] id;
        logic [FLOWID_W-1:0] t2_ids [3];
        t2_ids = '{4'd3, 4'd7, 4'd1};
        bus.close_val      = 1'b0;
        bus.close_flowid   = '0;
        bus.flowid_ret_rdy = 1'b1;
        repeat (3) tick();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        repeat (6) tick();
        chk("post_rst_close_rdy", bus.close_rdy, 1);

        close_one(4'd5, t);
        @(negedge clk);
        chk("t1_pending1", bus.pending_cnt, 1);
        wait_ret("t1", c, id);
        chk("t1_latency", c - t, 17);
        chk("t1_id", id, 5);
        @(negedge clk);
        chk("t1_pending0", bus.pending_cnt, 0);
        repeat (5) tick();

        close_one(4'd3, t);
        close_one(4'd7, t0);
        close_one(4'd1, t0);
        for (int i = 0; i < 3; i++) begin
            wait_ret("t2", c, id);
            chk("t2_cycle", c - t, 17 + i);
            chk("t2_id", id, t2_ids[i]);
        end
        repeat (5) tick();

        bus.flowid_ret_rdy = 1'b0;
        close_one(4'd9, t);
        wait_ret("t3", c, id);
        chk("t3_latency", c - t, 17);
        repeat (40) begin
            @(negedge clk);
            chk("t3_hold_val", bus.flowid_ret_val, 1);
            chk("t3_hold_id", bus.flowid_ret_id, 9);
        end
        tick();
        bus.flowid_ret_rdy = 1'b1;
        @(negedge clk);
        chk("t3_fire_val", bus.flowid_ret_val, 1);
        @(negedge clk);
        chk("t3_released", bus.flowid_ret_val, 0);
        repeat (5) tick();

        bus.flowid_ret_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            close_one(FLOWID_W'(i), t);
            if (i == 0) t0 = t;
        end
        bus.close_val    = 1'b1;
        bus.close_flowid = 4'd12;
        @(negedge clk);
        chk("t4_cycle", cyc - t0, 16);
        chk("t4_full_rdy", bus.close_rdy, 0);
        chk("t4_full_pending", bus.pending_cnt, 16);
        tick();
        bus.close_val = 1'b0;
        @(negedge clk);
        chk("t4_17th_blocked", bus.pending_cnt, 16);
        chk("t4_rdy_back", bus.close_rdy, 1);
        tick();
        bus.flowid_ret_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_ret("t4_drain", c, id);
            chk("t4_drain_id", id, i);
        end
        repeat (5) tick();

        for (int i = 0; i < 300 && ((cyc - rel_cyc) % 256) != 250; i++) tick();
        close_one(4'd2, t);
        wait_ret("t5", c, id);
        chk("t5_wrap_latency", c - t, 17);
        chk("t5_wrap_id", id, 2);
        repeat (3) tick();

        close_one(4'd4, t);
        close_one(4'd6, t);
        close_one(4'd8, t);
        repeat (5) tick();
        chk("t6_pre_pending", bus.pending_cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_pending", bus.pending_cnt, 0);
        chk("t6_async_val", bus.flowid_ret_val, 0);
        chk("t6_async_id", bus.flowid_ret_id, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.flowid_ret_val) n++;
        end
        chk("t6_no_return", n, 0);
        chk("t6_pending", bus.pending_cnt, 0);
        chk("t6_close_rdy", bus.close_rdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
